fifo_stream_reader: RTL and testbench

//  Downstream drain stage for synchronous_fifo. Issues read requests against the FIFO

---
 rtl/fifo_stream_reader_if.sv | 22 ++
 rtl/fifo_stream_reader.sv | 68 ++++++
 tb/tb_fifo_stream_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream, as seen by the drain stage.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_enb;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_enb, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_enb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a framed valid/ready stream,
// using a 3-entry skid buffer so backpressure never costs throughput.
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic                 idle
);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [2:0][WIDTH-1:0] buf_q;
  logic [1:0]            rd_ptr, wr_ptr, buf_cnt;
  logic                  inflight;
  logic [BW-1:0]         beat_cnt;
  logic                  rd_issue, push, pop, last_beat;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every read in flight so a landing beat always fits.
  assign rd_issue  = rstn & enable & ~bus.fifo_empty &
                     (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3);
  assign push      = inflight;
  assign pop       = bus.m_valid & bus.m_ready;
  assign last_beat = (beat_cnt == BW'(PKT_LEN - 1));

  assign bus.fifo_rd_enb = rd_issue;
  assign bus.m_valid     = (buf_cnt != 2'd0);
  assign bus.m_data      = buf_q[rd_ptr];
  assign bus.m_last      = bus.m_valid & last_beat;
  assign idle            = ~inflight & (buf_cnt == 2'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      buf_cnt  <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      inflight <= rd_issue;
      if (push) begin
        buf_q[wr_ptr] <= bus.fifo_rd_data;
        wr_ptr        <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
      // Framing survives enable toggles; only reset realigns it.
      if (pop) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
        if (last_beat) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: behavioural FIFO feeding the reader, write-order scoreboard, per-cycle compare.
module tb_fifo_stream_reader;
  localparam int W = 8, PL = 4, CW = 16;

  logic          clk = 1'b0, rstn = 1'b0, enable = 1'b1;
  logic [CW-1:0] pkt_cnt;
  logic          idle;
  logic          hold_empty = 1'b0;

  fifo_stream_reader_if #(.WIDTH(W)) bus ();

  fifo_stream_reader #(.WIDTH(W), .PKT_LEN(PL), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bus(bus), .pkt_cnt(pkt_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural FIFO: one-cycle read latency.
  logic [W-1:0] fmem [0:1023];
  int wr_n = 0, rd_n = 0, reads_acc = 0;
  assign bus.fifo_empty = hold_empty | (wr_n == rd_n);
  always @(posedge clk) begin
    if (!rstn) reads_acc <= 0;
    else if (bus.fifo_rd_enb) begin
      bus.fifo_rd_data <= fmem[rd_n & 1023];
      rd_n             <= rd_n + 1;
      reads_acc        <= reads_acc + 1;
    end
  end

  // Stream model: beats leave in write order, every PL-th beat since reset is last.
  logic [W-1:0] exp_q [$];
  int beats = 0, pkts = 0, cyc = 0, first_rd = -1, first_vld = -1, n_last = 0;
  logic [W-1:0] last_d = '0, prev_d = '0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, exp_last;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("reset_outs", {bus.m_valid, bus.m_last, bus.fifo_rd_enb, idle}, 4'b0001);
      chk("reset_pkt_cnt", pkt_cnt, 0);
      chk("reset_m_data", bus.m_data, 0);
      exp_q.delete();
      beats = 0; pkts = 0; prev_v = 1'b0;
    end else begin
      if (first_rd < 0 && bus.fifo_rd_enb) first_rd = cyc;
      if (first_vld < 0 && bus.m_valid) first_vld = cyc;
      chk("rd_while_empty", bus.fifo_rd_enb & bus.fifo_empty, 0);
      chk("outstanding_le3", (reads_acc - beats) <= 3, 1);
      chk("pkt_cnt", pkt_cnt, pkts[CW-1:0]);
      if (prev_v && !prev_r)
        chk("hold_stable", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, prev_l, prev_d});
      if (bus.m_valid) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_last = ((beats % PL) == PL - 1);
          chk("m_data", bus.m_data, exp_q[0]);
          chk("m_last", bus.m_last, exp_last);
          if (bus.m_ready) begin
            void'(exp_q.pop_front());
            beats++;
            if (exp_last) begin pkts++; n_last++; last_d = bus.m_data; end
          end
        end
      end
      prev_v = bus.m_valid; prev_r = bus.m_ready;
      prev_d = bus.m_data;  prev_l = bus.m_last;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_data(input logic [W-1:0] d);
    fmem[wr_n & 1023] = d;
    wr_n++;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || !idle) && t < 500) begin step(1); t++; end
    chk(nm, t < 500, 1);
  endtask

  int r0, b0, t, pushed;

  initial begin
    bus.m_ready = 1'b1;
    bus.fifo_rd_data = '0;
    // 1: reset held while FIFO shows data
    fmem[0] = 8'hEE; wr_n = 1;
    step(3);
    chk("t1_rd_enb", bus.fifo_rd_enb, 0);
    chk("t1_valid_idle", {bus.m_valid, idle}, 2'b01);
    chk("t1_pkt_cnt", pkt_cnt, 0);
    wr_n = rd_n;

    // 2: preloaded back-to-back drain
    for (int i = 0; i < 8; i++) push_data(8'h10 + W'(i));
    first_rd = -1; first_vld = -1;
    rstn = 1'b1;
    wait_drain("t2_drain");
    chk("t2_latency", first_vld - first_rd, 2);
    chk("t2_beats", beats, 8);
    chk("t2_pkt_cnt", pkt_cnt, 2);
    chk("t2_last_data", last_d, 8'h17);
    chk("t2_n_last", n_last, 2);
    chk("t2_idle", idle, 1);

    // 3: full backpressure, then release
    bus.m_ready = 1'b0;
    r0 = reads_acc;
    for (int i = 0; i < 8; i++) push_data(8'h10 + W'(i));
    step(10);
    chk("t3_reads", reads_acc - r0, 3);
    chk("t3_rd_enb", bus.fifo_rd_enb, 0);
    chk("t3_head", {bus.m_valid, bus.m_data}, {1'b1, 8'h10});
    bus.m_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_beats", beats, 16);
    chk("t3_pkt_cnt", pkt_cnt, 4);

    // 4: random empty flag, random refill and ready
    pushed = 0;
    while (pushed < 24) begin
      hold_empty  = $urandom_range(0, 1);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin push_data(8'h80 + W'(pushed)); pushed++; end
      step(1);
    end
    hold_empty = 1'b0; bus.m_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_beats", beats, 40);
    chk("t4_pkt_cnt", pkt_cnt, 10);

    // 5: drop enable after two beats, finish packet after re-enable
    b0 = beats;
    for (int i = 0; i < 6; i++) push_data(8'h40 + W'(i));
    t = 0;
    while (beats < b0 + 2 && t < 100) begin step(1); t++; end
    chk("t5_two_beats", t < 100, 1);
    enable = 1'b0;
    t = 0;
    while (!idle && t < 100) begin step(1); t++; end
    chk("t5_idle", idle, 1);
    chk("t5_fifo_left", (wr_n - rd_n) > 0, 1);
    chk("t5_partial", (beats - b0) < 6, 1);
    step(3);
    chk("t5_no_reads", bus.fifo_rd_enb, 0);
    enable = 1'b1;
    wait_drain("t5_drain");
    chk("t5_pkt_cnt", pkt_cnt, 11);
    chk("t5_last_data", last_d, 8'h43);

    // 6: async reset mid-packet, then a fresh packet
    b0 = beats;
    for (int i = 0; i < 8; i++) push_data(8'h50 + W'(i));
    t = 0;
    while (beats < b0 + 1 && t < 100) begin step(1); t++; end
    bus.m_ready = 1'b0;
    step(3);
    chk("t6_valid_before", bus.m_valid, 1);
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", bus.m_valid, 0);
    chk("t6_async_pkt_cnt", pkt_cnt, 0);
    step(2);
    wr_n = rd_n;
    rstn = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_data(8'h60 + W'(i));
    wait_drain("t6_drain");
    chk("t6_beats", beats, 8);
    chk("t6_pkt_cnt", pkt_cnt, 2);
    chk("t6_last_data", last_d, 8'h67);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
